// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the main-memory arbiter.
// FSM encodings are plain constants so older flows can consume them unchanged.
package mem_arb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_GRANT = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

   // Holds the values 0..max_out inclusive.
   function automatic int cnt_width(input int max_out);
      return $clog2(max_out + 1);
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational rotate-priority selector: one-hot winner from a request vector.
// With rr_mode low the search ignores start and begins at index 0.
module rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   input  logic             rr_mode,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] win_idx,
   output logic             found
);

   always_comb begin
      logic [IDX_W:0] idx;
      grant   = '0;
      win_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int i = 0; i < N; i++) begin
         idx = rr_mode ? ({1'b0, start} + (IDX_W+1)'(i)) : (IDX_W+1)'(i);
         if (idx >= (IDX_W+1)'(N)) begin
            idx = idx - (IDX_W+1)'(N);
         end
         if (!found && req[idx[IDX_W-1:0]]) begin
            grant[idx[IDX_W-1:0]] = 1'b1;
            win_idx               = idx[IDX_W-1:0];
            found                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one pipelined main memory among NUM_PORTS cache requestors with
// grant locking, outstanding-read tracking and per-port back-pressure.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no owner; pick a winner from pending requests
//   ST_GRANT | owner's commands forwarded combinationally to memory
//   ST_DRAIN | owner released with reads in flight; wait for all returns
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS       = 2,
   parameter int ADDR_W          = 16,
   parameter int DATA_W          = 16,
   parameter int MAX_OUTSTANDING = 4,
   parameter int RR_MODE         = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          port_ren,
   input  logic [NUM_PORTS-1:0]          port_wen,
   input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   port_wdata,
   output logic [NUM_PORTS-1:0]          port_grant,
   output logic [NUM_PORTS-1:0]          port_ready,
   output logic [DATA_W-1:0]             port_rdata,
   output logic [NUM_PORTS-1:0]          port_data_valid,
   output logic                          mem_ren,
   output logic                          mem_wen,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata,
   input  logic                          mem_data_valid,
   output logic                          err
);

   localparam int IDX_W = idx_width(NUM_PORTS);
   localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

   state_t                 state;
   logic [NUM_PORTS-1:0]   grant_q;
   logic [IDX_W-1:0]       owner;
   logic [IDX_W-1:0]       rr_ptr;
   logic [IDX_W-1:0]       next_ptr;
   logic [CNT_W-1:0]       outstanding;
   logic [CNT_W-1:0]       out_next;
   logic [CNT_W-1:0]       quiet_cnt;
   logic                   err_q;

   logic [NUM_PORTS-1:0]   req_vec;
   logic [NUM_PORTS-1:0]   pick_grant;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_found;

   logic                   own_ren;
   logic                   own_wen;
   logic [ADDR_W-1:0]      own_addr;
   logic [DATA_W-1:0]      own_wdata;
   logic                   in_grant;
   logic                   rd_room;
   logic                   issue_rd;
   logic                   issue_wr;
   logic                   ret;
   logic                   spurious;

   assign req_vec = port_ren | port_wen;

   rr_pick #(
      .N     (NUM_PORTS),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (req_vec),
      .start   (rr_ptr),
      .rr_mode (RR_MODE != 0),
      .grant   (pick_grant),
      .win_idx (pick_idx),
      .found   (pick_found)
   );

   always_comb begin
      own_ren   = 1'b0;
      own_wen   = 1'b0;
      own_addr  = '0;
      own_wdata = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (owner == IDX_W'(i)) begin
            own_ren   = port_ren[i];
            own_wen   = port_wen[i];
            own_addr  = port_addr[i*ADDR_W +: ADDR_W];
            own_wdata = port_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign in_grant = (state == ST_GRANT);
   // A return in the same cycle frees a slot, so a full pipeline keeps streaming.
   assign rd_room  = (outstanding < CNT_W'(MAX_OUTSTANDING)) || mem_data_valid;
   assign issue_wr = in_grant && own_wen;
   assign issue_rd = in_grant && own_ren && !own_wen && rd_room;
   assign ret      = mem_data_valid && (outstanding != '0);
   assign out_next = outstanding + CNT_W'(issue_rd) - CNT_W'(ret);
   assign next_ptr = (owner == IDX_W'(NUM_PORTS - 1)) ? '0 : owner + IDX_W'(1);

   // Returns shortly after reset belong to reads the reset discarded.
   assign spurious = mem_data_valid && (outstanding == '0) && (quiet_cnt == '0);

   assign mem_ren         = issue_rd;
   assign mem_wen         = issue_wr;
   assign mem_addr        = (issue_rd || issue_wr) ? own_addr : '0;
   assign mem_wdata       = issue_wr ? own_wdata : '0;
   assign port_grant      = grant_q;
   assign port_ready      = (issue_rd || issue_wr) ? grant_q : '0;
   assign port_rdata      = mem_rdata;
   assign port_data_valid = ((state != ST_IDLE) && mem_data_valid) ? grant_q : '0;
   assign err             = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         grant_q     <= '0;
         owner       <= '0;
         rr_ptr      <= '0;
         outstanding <= '0;
         quiet_cnt   <= CNT_W'(MAX_OUTSTANDING);
         err_q       <= 1'b0;
      end else begin
         outstanding <= out_next;
         if (quiet_cnt != '0) begin
            quiet_cnt <= quiet_cnt - CNT_W'(1);
         end
         if (spurious || (in_grant && own_ren && own_wen)) begin
            err_q <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  grant_q <= pick_grant;
                  owner   <= pick_idx;
                  state   <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (!(own_ren || own_wen)) begin
                  rr_ptr <= next_ptr;
                  if (out_next == '0) begin
                     state   <= ST_IDLE;
                     grant_q <= '0;
                  end else begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (out_next == '0) begin
                  state   <= ST_IDLE;
                  grant_q <= '0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-4 memory model with a read scoreboard on a
// round-robin instance, plus a fixed-priority instance exercised with writes.
module tb_mem_arbiter;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  ren = '0;
   logic [1:0]  wen = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [1:0]  grant, ready, dv;
   logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_ren, mem_wen, mem_dv, err;

   logic [1:0]  fp_ren = '0;
   logic [1:0]  fp_wen = '0;
   logic [31:0] fp_addr = {16'h00A2, 16'h00A0};
   logic [31:0] fp_wdata = {16'h2222, 16'h1111};
   logic [1:0]  fp_grant, fp_ready, fp_dv;
   logic [15:0] fp_rdata, fp_mem_addr, fp_mem_wdata;
   logic        fp_mem_ren, fp_mem_wen, fp_err;

   logic [15:0] mem [0:255];
   logic [LAT-1:0] pv = '0;
   logic [15:0] pd [0:LAT-1];
   logic        spur = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [15:0] sb [$];

   always #5 clk = ~clk;

   mem_arbiter #(
      .NUM_PORTS(2), .ADDR_W(16), .DATA_W(16), .MAX_OUTSTANDING(2), .RR_MODE(1)
   ) dut (
      .clk(clk), .rst(rst),
      .port_ren(ren), .port_wen(wen), .port_addr(addr), .port_wdata(wdata),
      .port_grant(grant), .port_ready(ready), .port_rdata(rdata),
      .port_data_valid(dv),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_valid(mem_dv),
      .err(err)
   );

   mem_arbiter #(
      .NUM_PORTS(2), .ADDR_W(16), .DATA_W(16), .MAX_OUTSTANDING(2), .RR_MODE(0)
   ) dut_fp (
      .clk(clk), .rst(rst),
      .port_ren(fp_ren), .port_wen(fp_wen), .port_addr(fp_addr), .port_wdata(fp_wdata),
      .port_grant(fp_grant), .port_ready(fp_ready), .port_rdata(fp_rdata),
      .port_data_valid(fp_dv),
      .mem_ren(fp_mem_ren), .mem_wen(fp_mem_wen), .mem_addr(fp_mem_addr),
      .mem_wdata(fp_mem_wdata), .mem_rdata(16'h0000), .mem_data_valid(1'b0),
      .err(fp_err)
   );

   // Pipelined memory: a read issued in cycle t returns in cycle t+LAT.
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], mem_ren};
      pd[0] <= mem[mem_addr[7:0]];
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
      if (mem_wen) mem[mem_addr[7:0]] <= mem_wdata;
   end
   assign mem_dv    = pv[LAT-1] | spur;
   assign mem_rdata = pd[LAT-1];

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
      checks++; if (ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", ready); end
      checks++; if (dv !== 2'b00) begin errors++; $display("FAIL reset_dv: got %b want 00", dv); end
      checks++; if ({mem_ren, mem_wen} !== 2'b00) begin errors++; $display("FAIL reset_cmd: got %b want 00", {mem_ren, mem_wen}); end
      checks++; if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_bus: got %h/%h want 0000/0000", mem_addr, mem_wdata); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (fp_grant !== 2'b00) begin errors++; $display("FAIL reset_fp_grant: got %b want 00", fp_grant); end
      @(negedge clk); rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_burst();
      logic [15:0] a, e;
      int issued, returned, cyc, stalls;
      logic exp_rdy;
      a = 16'h0040; issued = 0; returned = 0; cyc = 0; stalls = 0;
      @(negedge clk); ren = 2'b10; addr[31:16] = a; #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL burst_req_cycle: got %b want 00", grant); end
      @(negedge clk); #1;
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL burst_grant: got %b want 10", grant); end
      while (returned < 8 && cyc < 200) begin
         exp_rdy = (issued < 8) && (((issued - returned) < 2) || mem_dv);
         checks++; if (ready !== {exp_rdy, 1'b0}) begin errors++; $display("FAIL burst_ready: got %b want %b (issued %0d returned %0d)", ready, {exp_rdy, 1'b0}, issued, returned); end
         if (issued < 8 && !ready[1]) stalls++;
         if (mem_dv) begin
            checks++; if (dv !== 2'b10) begin errors++; $display("FAIL burst_dv: got %b want 10", dv); end
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL burst_rdata: got %h want none pending", rdata);
            end else begin
               e = sb.pop_front();
               if (rdata !== e) begin errors++; $display("FAIL burst_rdata: got %h want %h", rdata, e); end
            end
            returned++;
         end else begin
            checks++; if (dv !== 2'b00) begin errors++; $display("FAIL burst_dv_quiet: got %b want 00", dv); end
         end
         if (ready[1]) begin
            sb.push_back(16'hC000 | {8'h00, a[7:0]});
            issued++;
            a = a + 16'd2;
         end
         checks++; if (grant !== 2'b10) begin errors++; $display("FAIL burst_hold: got %b want 10", grant); end
         @(negedge clk); ren[1] = (issued < 8); addr[31:16] = a; #1; cyc++;
      end
      checks++; if (returned != 8) begin errors++; $display("FAIL burst_count: got %0d want 8", returned); end
      checks++; if (stalls == 0) begin errors++; $display("FAIL burst_backpressure: got %0d stall cycles want >0", stalls); end
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL burst_release: got %b want 00", grant); end
      ren = '0;
      sb.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write_readback();
      int wcount, cyc;
      logic [15:0] e;
      wcount = 0;
      @(negedge clk); wen = 2'b10; addr[31:16] = 16'h0010; wdata[31:16] = 16'hBEEF; #1;
      if (mem_wen) wcount++;
      @(negedge clk); #1;
      checks++; if ({mem_wen, mem_ren} !== 2'b10) begin errors++; $display("FAIL wr_cmd: got %b want 10", {mem_wen, mem_ren}); end
      checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL wr_addr: got %h want 0010", mem_addr); end
      checks++; if (mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_data: got %h want beef", mem_wdata); end
      checks++; if (ready !== 2'b10) begin errors++; $display("FAIL wr_ready: got %b want 10", ready); end
      if (mem_wen) wcount++;
      @(negedge clk); wen = '0; wdata = '0; #1;
      if (mem_wen) wcount++;
      repeat (2) begin @(negedge clk); #1; if (mem_wen) wcount++; end
      checks++; if (wcount != 1) begin errors++; $display("FAIL wr_single: got %0d write cycles want 1", wcount); end
      @(negedge clk); ren = 2'b10; addr[31:16] = 16'h0010; #1;
      cyc = 0;
      while (!ready[1] && cyc < 20) begin @(negedge clk); #1; cyc++; end
      checks++;
      if (!ready[1]) begin
         errors++; $display("FAIL rb_ready: got timeout want accept");
      end else begin
         sb.push_back(16'hBEEF);
         if (mem_addr !== 16'h0010) begin errors++; $display("FAIL rb_addr: got %h want 0010", mem_addr); end
      end
      @(negedge clk); ren = '0; #1;
      cyc = 0;
      while (!mem_dv && cyc < 20) begin @(negedge clk); #1; cyc++; end
      checks++;
      if (!mem_dv || sb.size() == 0) begin
         errors++; $display("FAIL rb_data: got no return want beef");
      end else begin
         e = sb.pop_front();
         if (rdata !== e || dv !== 2'b10) begin errors++; $display("FAIL rb_data: got %h dv %b want %h dv 10", rdata, dv, e); end
      end
      sb.delete();
      repeat (3) @(negedge clk);
   endtask

   task automatic test_rr_contention();
      @(negedge clk); wen = 2'b11; addr = {16'h0082, 16'h0080}; wdata = {16'h2222, 16'h1111}; #1;
      @(negedge clk); #1;
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rr_first: got %b want 01", grant); end
      checks++; if (ready !== 2'b01 || mem_addr !== 16'h0080) begin errors++; $display("FAIL rr_first_cmd: got %b/%h want 01/0080", ready, mem_addr); end
      @(negedge clk); wen[0] = 1'b0; #1;
      checks++; if (ready !== 2'b00) begin errors++; $display("FAIL rr_release_ready: got %b want 00", ready); end
      @(negedge clk); wen[0] = 1'b1; #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_idle: got %b want 00", grant); end
      @(negedge clk); #1;
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rr_second: got %b want 10", grant); end
      checks++; if (mem_addr !== 16'h0082 || mem_wdata !== 16'h2222) begin errors++; $display("FAIL rr_second_cmd: got %h/%h want 0082/2222", mem_addr, mem_wdata); end
      @(negedge clk); wen[1] = 1'b0; #1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rr_third: got %b want 01", grant); end
      @(negedge clk); wen = '0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_fixed_priority();
      @(negedge clk); fp_wen = 2'b11; #1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         checks++; if (fp_grant !== 2'b01) begin errors++; $display("FAIL fp_win_%0d: got %b want 01", k, fp_grant); end
         checks++; if (fp_mem_addr !== 16'h00A0 || fp_mem_wen !== 1'b1) begin errors++; $display("FAIL fp_cmd_%0d: got %h/%b want 00a0/1", k, fp_mem_addr, fp_mem_wen); end
         @(negedge clk); fp_wen[0] = 1'b0; #1;
         @(negedge clk); fp_wen[0] = 1'b1; #1;
      end
      @(negedge clk); #1;
      checks++; if (fp_grant !== 2'b01) begin errors++; $display("FAIL fp_win_last: got %b want 01", fp_grant); end
      @(negedge clk); fp_wen = 2'b10; #1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      checks++; if (fp_grant !== 2'b10 || fp_ready !== 2'b10) begin errors++; $display("FAIL fp_port1: got %b/%b want 10/10", fp_grant, fp_ready); end
      checks++; if (fp_mem_wdata !== 16'h2222 || fp_mem_ren !== 1'b0 || fp_dv !== 2'b00) begin errors++; $display("FAIL fp_port1_cmd: got %h ren %b dv %b want 2222 ren 0 dv 00", fp_mem_wdata, fp_mem_ren, fp_dv); end
      checks++; if (fp_err !== 1'b0 || fp_rdata !== 16'h0000) begin errors++; $display("FAIL fp_err: got %b/%h want 0/0000", fp_err, fp_rdata); end
      @(negedge clk); fp_wen = '0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_errors();
      @(negedge clk); #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clean: got %b want 0", err); end
      @(negedge clk); spur = 1'b1; #1;
      checks++; if (dv !== 2'b00) begin errors++; $display("FAIL err_spur_dv: got %b want 00", dv); end
      @(negedge clk); spur = 1'b0; #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_spur: got %b want 1", err); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_rst_clear: got %b want 0", err); end
      repeat (3) @(negedge clk);
      @(negedge clk); ren = 2'b01; wen = 2'b01; addr[15:0] = 16'h0090; wdata[15:0] = 16'h5555; #1;
      @(negedge clk); #1;
      checks++; if ({mem_wen, mem_ren} !== 2'b10) begin errors++; $display("FAIL err_both_cmd: got %b want 10", {mem_wen, mem_ren}); end
      @(negedge clk); ren = '0; wen = '0; wdata = '0; #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_both: got %b want 1", err); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid_burst();
      int cyc;
      logic [15:0] e;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL mid_pre_err: got %b want 1", err); end
      @(negedge clk); ren = 2'b01; addr[15:0] = 16'h0040; #1;
      @(negedge clk); #1;
      checks++; if (ready !== 2'b01) begin errors++; $display("FAIL mid_rd1: got %b want 01", ready); end
      @(negedge clk); #1;
      checks++; if (ready !== 2'b01) begin errors++; $display("FAIL mid_rd2: got %b want 01", ready); end
      @(negedge clk); ren = '0; #1;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL mid_grant: got %b want 00", grant); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (dv !== 2'b00) begin errors++; $display("FAIL mid_drop_%0d: got %b want 00", k, dv); end
         @(negedge clk); #1;
         checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err_%0d: got %b want 0", k, err); end
      end
      sb.delete();
      @(negedge clk); ren = 2'b01; addr[15:0] = 16'h0044; #1;
      cyc = 0;
      while (!ready[0] && cyc < 20) begin @(negedge clk); #1; cyc++; end
      checks++;
      if (!ready[0]) begin errors++; $display("FAIL mid_fresh_ready: got timeout want accept"); end
      else sb.push_back(16'hC044);
      @(negedge clk); ren = '0; #1;
      cyc = 0;
      while (!mem_dv && cyc < 20) begin @(negedge clk); #1; cyc++; end
      checks++;
      if (!mem_dv || sb.size() == 0) begin
         errors++; $display("FAIL mid_fresh_data: got no return want c044");
      end else begin
         e = sb.pop_front();
         if (rdata !== e || dv !== 2'b01) begin errors++; $display("FAIL mid_fresh_data: got %h dv %b want %h dv 01", rdata, dv, e); end
      end
      @(negedge clk); #1;
      checks++; if (grant !== 2'b00 || err !== 1'b0) begin errors++; $display("FAIL mid_final: got %b/%b want 00/0", grant, err); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
      for (int i = 0; i < LAT; i++) pd[i] = '0;
      test_reset();
      test_burst();
      test_write_readback();
      test_rr_contention();
      test_fixed_priority();
      test_errors();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit want completion");
      $fatal(1, "bench did not complete");
   end

endmodule
